// File: rtl/addsub_serial.sv
// addsub_serial: digit-serial adder/subtractor with accumulate mode, carry/overflow flags
// and a one-cycle done pulse, driven through a start/ready/busy handshake.
module addsub_serial #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic             acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             ovf,
  output logic             done
);
  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW = STEPS > 1 ? $clog2(STEPS) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b, r_res, w_res;
  logic [CW-1:0] r_cnt;
  logic r_c, r_amsb, r_bmsb, w_go, w_last;
  logic [DIGIT:0] w_dsum;
  always_comb begin
    w_go = r_state == IDLE && start && ready;
    w_last = r_state == RUN && r_cnt == CW'(STEPS - 1);
    w_next = w_go ? RUN : w_last ? IDLE : r_state;
    w_dsum = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_c};
    w_res = WIDTH'({w_dsum[DIGIT-1:0], r_res} >> DIGIT);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  // operand MSBs are kept separately because r_a/r_b are shifted away during RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      y      <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      r_a    <= '0;
      r_b    <= '0;
      r_res  <= '0;
      r_cnt  <= '0;
      r_c    <= 1'b0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
    end else begin
      ready <= w_next == IDLE;
      busy  <= w_next == RUN;
      done  <= w_last;
      if (w_go) begin
        r_a    <= acc ? y : a;
        r_b    <= op ? ~b : b;
        r_c    <= op;
        r_cnt  <= '0;
        r_amsb <= acc ? y[WIDTH-1] : a[WIDTH-1];
        r_bmsb <= op ? ~b[WIDTH-1] : b[WIDTH-1];
      end else if (r_state == RUN) begin
        r_a   <= r_a >> DIGIT;
        r_b   <= r_b >> DIGIT;
        r_c   <= w_dsum[DIGIT];
        r_res <= w_res;
        r_cnt <= r_cnt + 1'b1;
        if (w_last) begin
          y     <= w_res;
          carry <= w_dsum[DIGIT];
          ovf   <= (r_amsb == r_bmsb) && (w_res[WIDTH-1] != r_amsb);
        end
      end
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// tb_addsub_serial: checks addsub_serial at DIGIT=1,2,4,8,16 against an arithmetic reference model.
module tb_addsub_serial;
  logic clk = 1'b0, rst = 1'b0;
  logic [4:0] st = '0;
  logic op = 1'b0, acc = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic [4:0] rdy, bsy, cy, ov, dn;
  logic [15:0] ys [5];
  logic [15:0] my [5];
  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 5; g++) begin : g_dut
    addsub_serial #(.WIDTH(16), .DIGIT(1 << g)) dut (
      .clk(clk), .rst(rst), .start(st[g]), .op(op), .acc(acc), .a(a), .b(b),
      .ready(rdy[g]), .busy(bsy[g]), .y(ys[g]), .carry(cy[g]), .ovf(ov[g]), .done(dn[g]));
  end

  // returns {ovf, carry, y} from plain signed/unsigned arithmetic
  function automatic logic [17:0] ref_op(input logic [15:0] x, input logic [15:0] z, input logic o);
    int sx, sz, s;
    logic [16:0] u;
    sx = $signed(x);
    sz = $signed(z);
    s = o ? sx - sz : sx + sz;
    u = o ? {1'b0, x} - {1'b0, z} : {1'b0, x} + {1'b0, z};
    return {(s > 32767 || s < -32768), o ? ~u[16] : u[16], u[15:0]};
  endfunction

  task automatic do_op(input int i, input logic [15:0] ta, input logic [15:0] tb, input logic to,
                       input logic tacc, input bit scr, output int lat, output int nb, output logic [17:0] res);
    a = ta; b = tb; op = to; acc = tacc; st[i] = 1'b1;
    @(posedge clk); #1 st[i] = 1'b0;
    lat = 0; nb = 0;
    while (!dn[i] && lat < 40) begin
      nb += int'(bsy[i]);
      if (scr) begin a = 16'($urandom); b = 16'($urandom); op = 1'($urandom); acc = 1'($urandom); end
      @(posedge clk); #1 lat++;
    end
    res = {ov[i], cy[i], ys[i]};
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) my[i] = '0;
    #12;
    n_tot++; if ({bsy, dn, rdy, cy, ov} !== 25'd0) $display("FAIL reset_flags got %h want 0", {bsy, dn, rdy, cy, ov}); else n_pass++;
    n_tot++; if (ys[2] !== 16'h0) $display("FAIL reset_y got %h want 0", ys[2]); else n_pass++;
    rst = 1'b1; #1;
    n_tot++; if (rdy !== 5'h00) $display("FAIL ready_before_edge got %b want 00000", rdy); else n_pass++;
    @(posedge clk); #1;
    n_tot++; if (rdy !== 5'h1f) $display("FAIL ready_after_edge got %b want 11111", rdy); else n_pass++;
  endtask

  task automatic test_add();
    int lat, nb; logic [17:0] r;
    do_op(2, 16'd3, 16'd4, 1'b0, 1'b0, 0, lat, nb, r);
    my[2] = 16'd7;
    n_tot++; if (lat !== 4) $display("FAIL add_latency got %0d want 4", lat); else n_pass++;
    n_tot++; if (nb !== 4) $display("FAIL add_busy_cycles got %0d want 4", nb); else n_pass++;
    n_tot++; if (r !== 18'h00007) $display("FAIL add_result got %h want 00007", r); else n_pass++;
    n_tot++; if (rdy[2] !== 1'b1) $display("FAIL add_ready_at_done got %b want 1", rdy[2]); else n_pass++;
    @(posedge clk); #1;
    n_tot++; if ({dn[2], bsy[2], rdy[2]} !== 3'b001) $display("FAIL add_after_done got %b want 001", {dn[2], bsy[2], rdy[2]}); else n_pass++;
  endtask

  task automatic test_sub_and_bounds();
    logic [15:0] ta [5] = '{16'd5, 16'd12, 16'h7fff, 16'hffff, 16'h8000};
    logic [15:0] tb [5] = '{16'd12, 16'd5, 16'd1, 16'd1, 16'd1};
    logic to [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [17:0] ex [5] = '{18'h0fff9, 18'h10007, 18'h28000, 18'h10000, 18'h37fff};
    int lat, nb; logic [17:0] r;
    for (int k = 0; k < 5; k++) begin
      do_op(2, ta[k], tb[k], to[k], 1'b0, 0, lat, nb, r);
      my[2] = ex[k][15:0];
      n_tot++; if (r !== ex[k]) $display("FAIL subbound_%0d got %h want %h", k, r, ex[k]); else n_pass++;
    end
  endtask

  task automatic test_acc();
    int lat, nb; logic [17:0] r, e;
    do_op(2, 16'd2, 16'd2, 1'b0, 1'b0, 0, lat, nb, r);
    n_tot++; if (r[15:0] !== 16'd4) $display("FAIL acc_seed got %h want 0004", r[15:0]); else n_pass++;
    do_op(2, 16'h1234, 16'd3, 1'b0, 1'b1, 0, lat, nb, r);
    n_tot++; if (r[15:0] !== 16'd7) $display("FAIL acc_add got %h want 0007", r[15:0]); else n_pass++;
    do_op(2, 16'h1234, 16'd10, 1'b1, 1'b1, 0, lat, nb, r);
    n_tot++; if (r[15:0] !== 16'hfffd) $display("FAIL acc_sub got %h want fffd", r[15:0]); else n_pass++;
    my[2] = 16'hfffd;
    for (int k = 0; k < 4; k++) begin
      logic [15:0] ra, rb; logic ro;
      ra = 16'($urandom); rb = 16'($urandom); ro = 1'($urandom);
      e = ref_op(ra, rb, ro);
      do_op(2, ra, rb, ro, 1'b0, 1, lat, nb, r);
      my[2] = e[15:0];
      n_tot++; if (r !== e) $display("FAIL scramble_%0d got %h want %h", k, r, e); else n_pass++;
    end
  endtask

  task automatic test_start_during_run();
    int nd = 0;
    a = 16'd100; b = 16'd23; op = 1'b0; acc = 1'b0; st[2] = 1'b1;
    @(posedge clk); #1 st[2] = 1'b0; a = 16'd900;
    @(posedge clk); #1 st[2] = 1'b1;
    @(posedge clk); #1 st[2] = 1'b0;
    for (int k = 0; k < 12; k++) begin @(posedge clk); #1 nd += int'(dn[2]); end
    my[2] = 16'd123;
    n_tot++; if (nd !== 1) $display("FAIL restart_done_pulses got %0d want 1", nd); else n_pass++;
    n_tot++; if (ys[2] !== 16'd123) $display("FAIL restart_result got %h want 007b", ys[2]); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int at [$];
    a = 16'd1000; b = 16'd1; op = 1'b0; acc = 1'b0; st[2] = 1'b1;
    for (int c = 1; c <= 20; c++) begin @(posedge clk); #1 if (dn[2]) at.push_back(c); end
    st[2] = 1'b0;
    my[2] = 16'd1001;
    n_tot++; if (at.size() !== 4) $display("FAIL b2b_count got %0d want 4", at.size()); else n_pass++;
    for (int k = 0; k < at.size(); k++) begin
      n_tot++; if (at[k] !== 5 * (k + 1)) $display("FAIL b2b_done_cycle_%0d got %0d want %0d", k, at[k], 5 * (k + 1)); else n_pass++;
    end
    n_tot++; if (ys[2] !== 16'd1001) $display("FAIL b2b_result got %h want 03e9", ys[2]); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    int nd = 0;
    a = 16'h1111; b = 16'h2222; op = 1'b0; acc = 1'b0; st[2] = 1'b1;
    @(posedge clk); #1 st[2] = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    #1;
    n_tot++; if (ys[2] !== 16'h0) $display("FAIL abort_y got %h want 0000", ys[2]); else n_pass++;
    n_tot++; if ({bsy[2], rdy[2], dn[2], cy[2], ov[2]} !== 5'b0) $display("FAIL abort_flags got %b want 00000", {bsy[2], rdy[2], dn[2], cy[2], ov[2]}); else n_pass++;
    repeat (2) begin @(posedge clk); #1 nd += int'(dn[2]); end
    rst = 1'b1; #1;
    n_tot++; if (rdy[2] !== 1'b0) $display("FAIL abort_ready_early got %b want 0", rdy[2]); else n_pass++;
    @(posedge clk); #1;
    n_tot++; if (rdy[2] !== 1'b1) $display("FAIL abort_ready_rise got %b want 1", rdy[2]); else n_pass++;
    repeat (6) begin @(posedge clk); #1 nd += int'(dn[2]); end
    n_tot++; if (nd !== 0) $display("FAIL abort_done_pulses got %0d want 0", nd); else n_pass++;
    n_tot++; if (ys[2] !== 16'h0) $display("FAIL abort_y_after got %h want 0000", ys[2]); else n_pass++;
    for (int i = 0; i < 5; i++) my[i] = '0;
  endtask

  task automatic test_sweep();
    int lat, nb; logic [17:0] r, e;
    logic [15:0] ra, rb; logic ro, rc;
    for (int i = 0; i < 5; i++) begin
      for (int v = 0; v < 1000; v++) begin
        ra = 16'($urandom); rb = 16'($urandom); ro = 1'($urandom); rc = ($urandom_range(0, 3) == 0);
        e = ref_op(rc ? my[i] : ra, rb, ro);
        do_op(i, ra, rb, ro, rc, 0, lat, nb, r);
        my[i] = e[15:0];
        n_tot++; if (lat !== (16 >> i)) $display("FAIL sweep_latency d=%0d got %0d want %0d", 1 << i, lat, 16 >> i); else n_pass++;
        n_tot++; if (r !== e) $display("FAIL sweep_result d=%0d got %h want %h", 1 << i, r, e); else n_pass++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_and_bounds();
    test_acc();
    test_start_during_run();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
